// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: funct3-derived access codes, FSM states
// and the access-size decode used by the alignment logic.
package lsu_pkg;

    // Load type codes
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LBU = 3'b001;
    localparam logic [2:0] LD_LH  = 3'b010;
    localparam logic [2:0] LD_LHU = 3'b011;
    localparam logic [2:0] LD_LW  = 3'b100;

    // Store type codes
    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2,
        StErr  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SzByte = 2'd0,
        SzHalf = 2'd1,
        SzWord = 2'd2
    } size_e;

    // Unknown load/store codes fall through to a full-word access.
    function automatic size_e access_size(input logic we, input logic [2:0] load_type,
                                          input logic [1:0] store_type);
        size_e sz;
        sz = SzWord;
        if (we) begin
            case (store_type)
                ST_SB:   sz = SzByte;
                ST_SH:   sz = SzHalf;
                default: sz = SzWord;
            endcase
        end else begin
            case (load_type)
                LD_LB, LD_LBU: sz = SzByte;
                LD_LH, LD_LHU: sz = SzHalf;
                default:       sz = SzWord;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Data-memory bus: req/ack handshake with byte enables. Signal names are
// given from the controller's point of view.
interface data_mem_ctrl_if;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load lane
// extraction with sign/zero extension, and misalignment detection.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  load_type_i,
    input  logic [1:0]  store_type_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_rep_o,
    output logic [31:0] rdata_ext_o,
    output logic        misaligned_o
);

    size_e       size;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte enables, replicated store data and alignment check.
    always_comb begin
        size         = access_size(we_i, load_type_i, store_type_i);
        be_o         = 4'b1111;
        wdata_rep_o  = wdata_i;
        misaligned_o = 1'b0;
        unique case (size)
            SzByte: begin
                wdata_rep_o = {4{wdata_i[7:0]}};
                if (we_i) be_o = 4'b0001 << addr_lo_i;
            end
            SzHalf: begin
                wdata_rep_o  = {2{wdata_i[15:0]}};
                misaligned_o = addr_lo_i[0];
                if (we_i) be_o = 4'b0011 << {addr_lo_i[1], 1'b0};
            end
            default: begin
                misaligned_o = |addr_lo_i;
            end
        endcase
    end

    // Load lane select and extension.
    always_comb begin
        byte_sel = rdata_i[7:0];
        unique case (addr_lo_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (load_type_i)
            LD_LB:   rdata_ext_o = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  rdata_ext_o = {24'h0, byte_sel};
            LD_LH:   rdata_ext_o = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  rdata_ext_o = {16'h0, half_sel};
            default: rdata_ext_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage sequencer: takes one load/store from the pipeline, runs a single
// req/ack transaction on the data-memory bus and stalls the pipeline until it
// completes, is rejected as misaligned, or times out.
module data_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    input  logic                  we_i,
    input  logic [2:0]            load_type_i,
    input  logic [1:0]            store_type_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [31:0]           rdata_o,
    output logic                  misalign_o,
    output logic                  bus_err_o,
    data_mem_ctrl_if.master       mem
);

    // Keep at least one counter bit when the timeout is disabled.
    localparam int unsigned CntW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TLast = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            bus_q, bus_d;
    logic            we_q;
    logic [2:0]      lt_q;
    logic [1:0]      st_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;

    logic            idle;
    logic            al_we;
    logic [2:0]      al_lt;
    logic [1:0]      al_st;
    logic [1:0]      al_addr;
    logic [31:0]     al_wdata;
    logic [3:0]      al_be;
    logic [31:0]     al_wdata_rep;
    logic [31:0]     al_rdata_ext;
    logic            al_misaligned;

    // In IDLE the aligner looks at the live request so misalignment is known
    // at accept time; otherwise it works only from the captured access.
    assign idle     = (state_q == StIdle);
    assign al_we    = idle ? we_i         : we_q;
    assign al_lt    = idle ? load_type_i  : lt_q;
    assign al_st    = idle ? store_type_i : st_q;
    assign al_addr  = idle ? addr_i[1:0]  : addr_q[1:0];
    assign al_wdata = idle ? wdata_i      : wdata_q;

    lsu_align u_align (
        .we_i         (al_we),
        .load_type_i  (al_lt),
        .store_type_i (al_st),
        .addr_lo_i    (al_addr),
        .wdata_i      (al_wdata),
        .rdata_i      (rdata_q),
        .be_o         (al_be),
        .wdata_rep_o  (al_wdata_rep),
        .rdata_ext_o  (al_rdata_ext),
        .misaligned_o (al_misaligned)
    );

    // State, timeout counter and capture registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bus_q   <= 1'b0;
            we_q    <= 1'b0;
            lt_q    <= '0;
            st_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            if (idle && req_valid_i) begin
                we_q    <= we_i;
                lt_q    <= load_type_i;
                st_q    <= store_type_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
            if (state_q == StReq && mem.mem_ack_i) begin
                rdata_q <= mem.mem_rdata_i;
            end
        end
    end

    // Next-state, pipeline handshake and memory bus outputs.
    always_comb begin
        state_d         = state_q;
        cnt_d           = '0;
        bus_d           = bus_q;
        stall_o         = 1'b0;
        done_o          = 1'b0;
        rdata_o         = '0;
        misalign_o      = 1'b0;
        bus_err_o       = 1'b0;
        mem.mem_req_o   = 1'b0;
        mem.mem_we_o    = 1'b0;
        mem.mem_addr_o  = '0;
        mem.mem_be_o    = '0;
        mem.mem_wdata_o = '0;
        unique case (state_q)
            StIdle: begin
                stall_o = req_valid_i;
                if (req_valid_i) begin
                    if (al_misaligned) begin
                        state_d = StErr;
                        bus_d   = 1'b0;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                stall_o         = 1'b1;
                mem.mem_req_o   = 1'b1;
                mem.mem_we_o    = we_q;
                mem.mem_addr_o  = {addr_q[31:2], 2'b00};
                mem.mem_be_o    = al_be;
                mem.mem_wdata_o = al_wdata_rep;
                // Ack takes priority over a timeout in the same cycle.
                if (mem.mem_ack_i) begin
                    state_d = StResp;
                end else if (TIMEOUT != 0 && cnt_q == CntW'(TLast)) begin
                    state_d = StErr;
                    bus_d   = 1'b1;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                done_o  = 1'b1;
                rdata_o = we_q ? 32'h0 : al_rdata_ext;
                state_d = StIdle;
            end
            StErr: begin
                misalign_o = ~bus_q;
                bus_err_o  = bus_q;
                state_d    = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with TIMEOUT=8. Inputs change just after
// the falling edge; outputs are sampled 1ns later.
module tb_data_mem_ctrl;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        we;
    logic [2:0]  load_type;
    logic [1:0]  store_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    data_mem_ctrl_if bus ();

    data_mem_ctrl #(
        .TIMEOUT (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .we_i         (we),
        .load_type_i  (load_type),
        .store_type_i (store_type),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .stall_o      (stall),
        .done_o       (done),
        .rdata_o      (rdata),
        .misalign_o   (misalign),
        .bus_err_o    (bus_err),
        .mem          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic w, input logic [2:0] lt, input logic [1:0] st,
                             input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid  = 1'b1;
        we         = w;
        load_type  = lt;
        store_type = st;
        addr       = a;
        wdata      = d;
        #1;
        check("stall_on_accept", {31'h0, stall}, 32'h1);
    endtask

    // Full access with ack k cycles after entering REQ; done is expected k+2
    // cycles after the accept cycle.
    task automatic run_access(input string tag, input logic w, input logic [2:0] lt,
                              input logic [1:0] st, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] mem_word, input int k,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_rdata);
        drive_req(w, lt, st, a, d);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i <= k; i++) begin
            #1;
            check({tag, "_req"}, {31'h0, bus.mem_req_o}, 32'h1);
            if (i == 0) begin
                check({tag, "_addr"}, bus.mem_addr_o, {a[31:2], 2'b00});
                check({tag, "_be"}, {28'h0, bus.mem_be_o}, {28'h0, exp_be});
                check({tag, "_we"}, {31'h0, bus.mem_we_o}, {31'h0, w});
                if (w) check({tag, "_wdata"}, bus.mem_wdata_o, exp_wdata);
            end
            if (i == k) begin
                bus.mem_ack_i   = 1'b1;
                bus.mem_rdata_i = mem_word;
            end
            @(negedge clk);
        end
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'h0;
        #1;
        check({tag, "_done"}, {31'h0, done}, 32'h1);
        check({tag, "_stall_done"}, {31'h0, stall}, 32'h0);
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_nobuserr"}, {31'h0, bus_err}, 32'h0);
        check({tag, "_reqlow"}, {31'h0, bus.mem_req_o}, 32'h0);
        @(negedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
    endtask

    task automatic run_misalign(input string tag, input logic w, input logic [2:0] lt,
                                input logic [1:0] st, input logic [31:0] a);
        drive_req(w, lt, st, a, 32'h1234_5678);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check({tag, "_misalign"}, {31'h0, misalign}, 32'h1);
        check({tag, "_stall"}, {31'h0, stall}, 32'h0);
        check({tag, "_req"}, {31'h0, bus.mem_req_o}, 32'h0);
        check({tag, "_done"}, {31'h0, done}, 32'h0);
        @(negedge clk);
        #1;
        check({tag, "_pulse"}, {31'h0, misalign}, 32'h0);
        check({tag, "_req2"}, {31'h0, bus.mem_req_o}, 32'h0);
    endtask

    initial begin
        rst             = 1'b1;
        req_valid       = 1'b0;
        we              = 1'b0;
        load_type       = LD_LW;
        store_type      = ST_SW;
        addr            = 32'h0;
        wdata           = 32'h0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_misalign", {31'h0, misalign}, 32'h0);
        check("rst_buserr", {31'h0, bus_err}, 32'h0);
        check("rst_req", {31'h0, bus.mem_req_o}, 32'h0);
        check("rst_addr", bus.mem_addr_o, 32'h0);
        check("rst_be", {28'h0, bus.mem_be_o}, 32'h0);
        rst = 1'b0;

        // Directed accesses
        run_access("sw", 1'b1, LD_LW, ST_SW, 32'h100, 32'hDEAD_BEEF, 32'h0, 2,
                   4'b1111, 32'hDEAD_BEEF, 32'h0);
        run_access("lb", 1'b0, LD_LB, ST_SW, 32'h103, 32'h0, 32'h8012_3456, 0,
                   4'b1111, 32'h0, 32'hFFFF_FF80);
        run_access("lbu", 1'b0, LD_LBU, ST_SW, 32'h103, 32'h0, 32'h8012_3456, 1,
                   4'b1111, 32'h0, 32'h0000_0080);
        run_access("sh", 1'b1, LD_LW, ST_SH, 32'h202, 32'h0000_ABCD, 32'h0, 0,
                   4'b1100, 32'hABCD_ABCD, 32'h0);
        run_access("lh", 1'b0, LD_LH, ST_SW, 32'h202, 32'h0, 32'h8001_1234, 1,
                   4'b1111, 32'h0, 32'hFFFF_8001);
        run_access("lhu", 1'b0, LD_LHU, ST_SW, 32'h202, 32'h0, 32'h8001_1234, 0,
                   4'b1111, 32'h0, 32'h0000_8001);
        run_access("lh_lo", 1'b0, LD_LH, ST_SW, 32'h200, 32'h0, 32'h8001_7FFF, 0,
                   4'b1111, 32'h0, 32'h0000_7FFF);
        run_access("sb", 1'b1, LD_LW, ST_SB, 32'h101, 32'h0000_005A, 32'h0, 0,
                   4'b0010, 32'h5A5A_5A5A, 32'h0);
        run_access("lb_l1", 1'b0, LD_LB, ST_SW, 32'h101, 32'h0, 32'h8012_3456, 0,
                   4'b1111, 32'h0, 32'h0000_0034);
        run_access("lw", 1'b0, LD_LW, ST_SW, 32'h104, 32'h0, 32'h1234_5678, 3,
                   4'b1111, 32'h0, 32'h1234_5678);
        run_access("ld_unk", 1'b0, 3'b111, ST_SW, 32'h108, 32'h0, 32'hCAFE_F00D, 0,
                   4'b1111, 32'h0, 32'hCAFE_F00D);
        run_access("st_unk", 1'b1, LD_LW, 2'b11, 32'h10C, 32'h0102_0304, 32'h0, 0,
                   4'b1111, 32'h0102_0304, 32'h0);

        // Misalignment
        run_misalign("lw_mis", 1'b0, LD_LW, ST_SW, 32'h101);
        run_misalign("sh_mis", 1'b1, LD_LW, ST_SH, 32'h203);
        run_misalign("sw11_mis", 1'b1, LD_LW, 2'b11, 32'h102);

        // Timeout: 8 REQ cycles without ack
        drive_req(1'b0, LD_LW, ST_SW, 32'h300, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("to_req", {31'h0, bus.mem_req_o}, 32'h1);
            check("to_no_err", {31'h0, bus_err}, 32'h0);
            @(negedge clk);
        end
        #1;
        check("to_buserr", {31'h0, bus_err}, 32'h1);
        check("to_req_low", {31'h0, bus.mem_req_o}, 32'h0);
        check("to_stall", {31'h0, stall}, 32'h0);
        check("to_misalign", {31'h0, misalign}, 32'h0);
        check("to_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        #1;
        check("to_pulse", {31'h0, bus_err}, 32'h0);
        check("to_idle_req", {31'h0, bus.mem_req_o}, 32'h0);

        // Ack on the 8th REQ cycle wins over the timeout
        run_access("ack8", 1'b0, LD_LW, ST_SW, 32'h304, 32'h0, 32'h0BAD_CAFE, 7,
                   4'b1111, 32'h0, 32'h0BAD_CAFE);

        // Reset during REQ, then a late ack
        drive_req(1'b1, LD_LW, ST_SW, 32'h400, 32'h5555_AAAA);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("rstreq_req", {31'h0, bus.mem_req_o}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rstreq_req_low", {31'h0, bus.mem_req_o}, 32'h0);
        check("rstreq_stall", {31'h0, stall}, 32'h0);
        check("rstreq_done", {31'h0, done}, 32'h0);
        check("rstreq_err", {31'h0, bus_err | misalign}, 32'h0);
        rst             = 1'b0;
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.mem_ack_i = 1'b0;
        #1;
        check("late_ack_done", {31'h0, done}, 32'h0);
        check("late_ack_req", {31'h0, bus.mem_req_o}, 32'h0);
        @(negedge clk);
        #1;
        check("late_ack_done2", {31'h0, done}, 32'h0);
        check("late_ack_rdata", rdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
